spi_phy_master: RTL



---
 rtl/spi_phy_pkg.sv | 19 +
 rtl/spi_phy_master_if.sv | 27 ++
 rtl/spi_sck_div.sv | 36 +++
 rtl/spi_phy_master.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/spi_phy_pkg.sv
// spi_phy_pkg
// Shared definitions for the SPI PHY family (master PHY and the SD-card PHY):
// the transfer state encoding, the two supported word lengths and the
// default SCK half-period.
package spi_phy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } spi_state_e;

  localparam int NARROW_BITS     = 8;
  localparam int WIDE_BITS       = 32;
  localparam int DEFAULT_CLK_DIV = 2;
  localparam int DEFAULT_DIV_W   = 8;

endpackage

// File: rtl/spi_phy_master_if.sv
// spi_phy_master_if
// Request interface between a protocol controller (LCD/SD) and the SPI PHY.
//   spi_mosi  [31:0] transmit word (narrow transfers use [7:0])
//   spi_begin        transfer request, level sensitive
//   spi_wide         1 = 32-bit transfer, 0 = 8-bit transfer
//   spi_cs           requested chip-select level (1 = deselect)
//   spi_busy         transfer in progress
//   spi_miso  [31:0] last received word
// Modports: master = controller side, slave = PHY side.
interface spi_phy_master_if;
  logic [31:0] spi_mosi;
  logic        spi_begin;
  logic        spi_wide;
  logic        spi_cs;
  logic        spi_busy;
  logic [31:0] spi_miso;

  modport master (
    output spi_mosi, spi_begin, spi_wide, spi_cs,
    input  spi_busy, spi_miso
  );

  modport slave (
    input  spi_mosi, spi_begin, spi_wide, spi_cs,
    output spi_busy, spi_miso
  );
endinterface

// File: rtl/spi_sck_div.sv
// spi_sck_div
// Phase-tick generator for the SPI PHYs. While run is high, tick pulses for
// one cycle every CLK_DIV cycles; the count restarts after every tick, so a
// phase change driven by tick always begins a full phase. Dropping run clears
// the count so the next phase starts from zero.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   run       counter enable (start/stop)
//   tick      end-of-phase strobe
module spi_sck_div
  import spi_phy_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int DIV_W   = DEFAULT_DIV_W
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (!run || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_phy_master.sv
// spi_phy_master
// SPI mode-0 master PHY. Serialises one 8- or 32-bit word per request, MSB
// first, while shifting MISO into a receive register. sck idles low; data is
// presented while sck is low and MISO is captured on the rising-edge cycle.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   bus       request interface (slave modport)
//   sck       SPI clock pin (registered, idles low)
//   mosi      SPI data-out pin (registered)
//   miso      SPI data-in pin
//   cs_n      chip-select pin (registered)
module spi_phy_master
  import spi_phy_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int DIV_W   = DEFAULT_DIV_W
) (
  input  logic            clk,
  input  logic            rst,
  spi_phy_master_if.slave bus,
  output logic            sck,
  output logic            mosi,
  input  logic            miso,
  output logic            cs_n
);

  spi_state_e  state_q, state_d;
  logic        busy_q, busy_d;
  logic [31:0] rx_word_q, rx_word_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic        armed_q, armed_d;
  logic        wide_q, wide_d;
  logic [30:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [5:0]  bits_q, bits_d;
  logic        rise_q, rise_d;
  logic        accept;
  logic        tick;
  logic        div_run;

  // A request is taken only from IDLE and only once per begin assertion.
  assign accept  = (state_q == IDLE) && bus.spi_begin && armed_q;
  assign div_run = (state_q == LOW) || (state_q == HIGH);

  spi_sck_div #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .run  (div_run),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOW;
      LOW:     if (tick) state_d = HIGH;
      HIGH:    if (tick) state_d = (bits_q == 6'd1) ? DONE : LOW;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin and status values are computed from the next state so that sck and
  // busy come straight out of flops. rise marks the first HIGH cycle, which
  // is when MISO is captured. tx holds the bits still to be sent below the
  // one currently on mosi.
  always_comb begin
    busy_d    = (state_d != IDLE);
    sck_d     = (state_d == HIGH);
    rise_d    = (state_d == HIGH) && (state_q != HIGH);
    rx_word_d = rx_word_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    armed_d   = armed_q;
    wide_d    = wide_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bits_d    = bits_q;

    if (!bus.spi_begin) armed_d = 1'b1;

    // cs_n only tracks the request while idle, so it is frozen for the whole
    // transfer and the start cycle already carries the requested level.
    if (state_q == IDLE) cs_n_d = bus.spi_cs;

    if (accept) begin
      armed_d = 1'b0;
      wide_d  = bus.spi_wide;
      rx_d    = '0;
      if (bus.spi_wide) begin
        mosi_d = bus.spi_mosi[31];
        tx_d   = bus.spi_mosi[30:0];
        bits_d = 6'(WIDE_BITS);
      end else begin
        mosi_d = bus.spi_mosi[7];
        tx_d   = {bus.spi_mosi[6:0], 24'h0};
        bits_d = 6'(NARROW_BITS);
      end
    end

    if (rise_q) rx_d = {rx_q[30:0], miso};

    if ((state_q == HIGH) && tick && (bits_q != 6'd1)) begin
      mosi_d = tx_q[30];
      tx_d   = {tx_q[29:0], 1'b0};
      bits_d = bits_q - 6'd1;
    end

    if (state_q == DONE) rx_word_d = wide_q ? rx_q : {24'h0, rx_q[7:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      rx_word_q <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      armed_q   <= 1'b1;
      wide_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      bits_q    <= '0;
      rise_q    <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      rx_word_q <= rx_word_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      armed_q   <= armed_d;
      wide_q    <= wide_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bits_q    <= bits_d;
      rise_q    <= rise_d;
    end
  end

  assign bus.spi_busy = busy_q;
  assign bus.spi_miso = rx_word_q;
  assign sck          = sck_q;
  assign mosi         = mosi_q;
  assign cs_n         = cs_n_q;

endmodule
